// File: rtl/backup_memory.sv
// Behavioural backing store for the host-side backup-memory path: tagged, line-granular
// reads/writes over a multi-beat wide bus. Optional command trace: define BACKUP_MEM_TRACE_EN.
module backup_memory #(
    parameter int DATA_BITS = 128,
    parameter int ADDR_BITS = 26,
    parameter int TAG_BITS  = 5,
    parameter int BEATS     = 4,
    parameter int DEPTH     = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int CNT_W  = $clog2(BEATS);
    localparam int RAM_AW = $clog2(DEPTH * BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [DATA_BITS-1:0] ram [0:DEPTH*BEATS-1];

    logic [1:0]           state_q,      state_d;
    logic [ADDR_BITS-1:0] line_q,       line_d;
    logic [TAG_BITS-1:0]  tag_q,        tag_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DATA_BITS-1:0] resp_data_q,  resp_data_d;
    logic [TAG_BITS-1:0]  resp_tag_q,   resp_tag_d;

    logic cmd_fire;
    logic wr_fire;

    // High line-address bits beyond DEPTH are dropped, so distinct addresses alias.
    function automatic logic [RAM_AW-1:0] ram_index(input logic [ADDR_BITS-1:0] line,
                                                    input logic [CNT_W-1:0]     beat);
        logic [ADDR_BITS-1:0] wrapped;
        wrapped = line % ADDR_BITS'(DEPTH);
        return RAM_AW'(32'(wrapped) * 32'(BEATS) + 32'(beat));
    endfunction

    assign mem_req_ready      = reset & (state_q == IDLE);
    assign mem_req_data_ready = reset & (state_q == WRITE);

    assign cmd_fire = mem_req_valid & mem_req_ready;
    assign wr_fire  = mem_req_data_valid & mem_req_data_ready;

    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_data  = resp_data_q;
    assign mem_resp_tag   = resp_tag_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        line_d       = line_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    line_d = mem_req_addr;
                    tag_d  = mem_req_tag;
                    cnt_d  = '0;
                    if (mem_req_rw) begin
                        state_d = WRITE;
                    end else begin
                        // Beat 0 issues on the accept edge so the response starts the next cycle.
                        state_d      = READ;
                        resp_valid_d = 1'b1;
                        resp_data_d  = ram[ram_index(mem_req_addr, '0)];
                        resp_tag_d   = mem_req_tag;
                        cnt_d        = CNT_W'(1);
                    end
                end
            end

            READ: begin
                resp_valid_d = 1'b1;
                resp_data_d  = ram[ram_index(line_q, cnt_q)];
                resp_tag_d   = tag_q;
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            line_q       <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // NOTE: the storage array has no reset so preloaded or written contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            ram[ram_index(line_q, cnt_q)] <= mem_req_data_bits;
        end
    end

`ifdef BACKUP_MEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            $display("MB: rw=%d addr=%x", mem_req_rw, {mem_req_addr, 6'd0});
        end
    end
`else
    // Default build carries no trace code; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_backup_memory.sv
// Directed bench for backup_memory: scoreboarded reads, writes with bubbles,
// address wrap on a 16-line instance, and reset abort of a read in flight.
module tb_backup_memory;

    localparam int DATA_BITS = 128;
    localparam int ADDR_BITS = 26;
    localparam int TAG_BITS  = 5;
    localparam int BEATS     = 4;
    localparam int DEPTH     = 16;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [TAG_BITS-1:0]  tag;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_req_data_valid;
    logic                 mem_req_data_ready;
    logic [DATA_BITS-1:0] mem_req_data_bits;
    logic                 mem_resp_valid;
    logic [DATA_BITS-1:0] mem_resp_data;
    logic [TAG_BITS-1:0]  mem_resp_tag;

    beat_t                exp_q[$];
    logic [DATA_BITS-1:0] model_mem [DEPTH*BEATS];
    int                   checks = 0;
    int                   passed = 0;
    int                   failed = 0;

    always #5 clk = ~clk;

    backup_memory #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS),
        .TAG_BITS (TAG_BITS),
        .BEATS    (BEATS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .mem_resp_tag      (mem_resp_tag)
    );

    task automatic check(input string name, input logic [DATA_BITS-1:0] obs,
                         input logic [DATA_BITS-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int midx(input logic [ADDR_BITS-1:0] line, input int b);
        return (int'(line) % DEPTH) * BEATS + b;
    endfunction

    function automatic logic [DATA_BITS-1:0] pattern(input logic [31:0] base, input int b);
        return {4{base + 32'(b)}};
    endfunction

    task automatic check_beat(input string name);
        beat_t e;
        check({name, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({name, "_data"}, mem_resp_data, e.data);
            check({name, "_tag"}, mem_resp_tag, e.tag);
        end
    endtask

    task automatic write_line(input logic [ADDR_BITS-1:0] addr, input logic [TAG_BITS-1:0] tag,
                              input logic [31:0] base, input int bubbles);
        logic [DATA_BITS-1:0] d;
        check("wr_cmd_ready", mem_req_ready, 1);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        step();
        mem_req_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b == 2) begin
                for (int k = 0; k < bubbles; k++) begin
                    check("wr_bubble_ready", mem_req_ready, 0);
                    check("wr_bubble_data_ready", mem_req_data_ready, 1);
                    step();
                end
            end
            d = pattern(base, b);
            check("wr_data_ready", mem_req_data_ready, 1);
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = d;
            model_mem[midx(addr, b)] = d;
            step();
            mem_req_data_valid = 1'b0;
            if (b < BEATS - 1) begin
                check("wr_mid_ready", mem_req_ready, 0);
            end
        end
        check("wr_done_ready", mem_req_ready, 1);
        check("wr_done_data_ready", mem_req_data_ready, 0);
        check("wr_resp_valid", mem_resp_valid, 0);
    endtask

    task automatic read_line(input logic [ADDR_BITS-1:0] addr, input logic [TAG_BITS-1:0] tag);
        for (int b = 0; b < BEATS; b++) begin
            exp_q.push_back('{data: model_mem[midx(addr, b)], tag: tag});
        end
        check("rd_cmd_ready", mem_req_ready, 1);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        step();
        mem_req_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            check("rd_resp_valid", mem_resp_valid, 1);
            check_beat("rd_beat");
            check("rd_cmd_ready_during", mem_req_ready, (b == BEATS - 1) ? 1 : 0);
            step();
        end
        check("rd_resp_valid_after", mem_resp_valid, 0);
        check("rd_sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        #2 reset = 1'b0;

        // Reset held three cycles.
        repeat (3) step();
        check("rst_ready", mem_req_ready, 0);
        check("rst_data_ready", mem_req_data_ready, 0);
        check("rst_resp_valid", mem_resp_valid, 0);
        check("rst_resp_data", mem_resp_data, 0);
        check("rst_resp_tag", mem_resp_tag, 0);
        reset = 1'b1;
        step();
        check("rst_release_ready", mem_req_ready, 1);

        // Write data offered before any command must be refused.
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = {4{32'hDEADBEEF}};
        #1 check("early_data_ready", mem_req_data_ready, 0);
        step();
        mem_req_data_valid = 1'b0;

        // Write then read back line 0x10.
        write_line(26'h10, 5'd3, 32'hA0A0_0000, 0);
        read_line(26'h10, 5'd7);

        // Two-cycle bubble between beats 1 and 2.
        write_line(26'h05, 5'd4, 32'hC0C0_0000, 2);
        read_line(26'h05, 5'd12);

        // Line 0x13 aliases line 0x3 on a 16-line store.
        write_line(26'h13, 5'd2, 32'hB0B0_0000, 0);
        read_line(26'h03, 5'd31);

        // Reset during beat 2 of a read aborts the transfer.
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back('{data: model_mem[midx(26'h10, b)], tag: 5'd9});
        end
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 26'h10;
        mem_req_tag   = 5'd9;
        step();
        mem_req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("abort_resp_valid", mem_resp_valid, 1);
            check_beat("abort_beat");
            if (b < 2) step();
        end
        reset = 1'b0;
        #1;
        check("abort_resp_valid_now", mem_resp_valid, 0);
        check("abort_resp_data", mem_resp_data, 0);
        check("abort_resp_tag", mem_resp_tag, 0);
        check("abort_ready", mem_req_ready, 0);
        repeat (2) begin
            step();
            check("abort_hold_valid", mem_resp_valid, 0);
        end
        reset = 1'b1;
        #1 check("abort_release_ready", mem_req_ready, 1);
        repeat (4) begin
            step();
            check("abort_no_stale", mem_resp_valid, 0);
            check("abort_idle_ready", mem_req_ready, 1);
        end
        check("abort_sb_drained", exp_q.size(), 0);

        // Contents survive reset.
        read_line(26'h10, 5'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
